pixel_compositor: RTL and testbench
===================================

# pixel_compositor

Per-pixel output stage between the layer generators (board, bullets, player, …) and the VGA DAC pins. It merges a parametrised number of colour layers using OR or priority mixing. When `over` is asserted, it runs a frame-synchronous game-over sequence: the background fades in steps, then the seven-segment "LOSE" banner blinks over it. Output is registered through a fixed two-stage pipeline.

## Interface
- `NUM_LAYERS`, 4: number of colour layers; layer 0 has highest priority.
- `CH_W`, 4: bits per colour channel; pixel width is `3*CH_W` (R in MSBs, then G, then B).
- `SEG_W`, 10: banner segment thickness in pixels.
- `SEG_H`, 40: banner segment length in pixels.
- `TEXT_X`, 120: banner left edge (hcount).
- `TEXT_Y`, 245: banner top edge (vcount).
- `TEXT_COLOR`, 12'h0FF: banner colour.
- `FADE_STEPS`, 3: maximum right-shift applied per channel; range 1..`CH_W`.
- `FADE_FRAMES`, 8: frames held at each fade step.
- `BLINK_FRAMES`, 30: frames the banner stays on, then off, per blink half-period.
- `clk`  in  1  pixel clock.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `layers`  in  `NUM_LAYERS*3*CH_W`  packed layer pixels; layer i occupies bits [i*3*CH_W +: 3*CH_W]; value 0 means transparent.
- `layer_en`  in  `NUM_LAYERS`  per-layer enable; a disabled layer is treated as 0.
- `mix_mode`  in  1  0 = bitwise OR of enabled layers; 1 = lowest-index nonzero enabled layer wins.
- `hcount`  in  11  current pixel column.
- `vcount`  in  10  current pixel row.
- `frame_start`  in  1  one-cycle pulse once per frame, during vertical blanking.
- `over`  in  1  game-over request, level.
- `final_pixel`  out  `3*CH_W`  composited pixel.
- `phase`  out  2  current state: 0 PLAY, 1 FADE, 2 MSG.

## Operation
- State machine, evaluated only on cycles where `frame_start`=1:
  - PLAY→FADE when `over`=1. `shift` becomes 1 and `frame_cnt` becomes 0.
  - FADE: `frame_cnt` increments. When it reaches `FADE_FRAMES-1`, it clears and `shift` increments. When `shift` = `FADE_STEPS` and `frame_cnt` wraps, the state goes to MSG with `blink_cnt`=0 and `text_on`=1.
  - MSG: `blink_cnt` increments. When it reaches `BLINK_FRAMES-1`, it clears and `text_on` toggles.
  - Any state→PLAY when `over`=0. On this transition `shift`, all counters and `text_on` clear.
  - If `frame_start` and the rising edge of `over` coincide, the PLAY→FADE transition is taken on that cycle.
- Mix:
  - OR mode: OR of all enabled layers.
  - Priority mode: the first enabled layer with a nonzero value wins; if none is nonzero, the result is 0.
- Fade: each channel of the mix result is logically shifted right by `shift`. `shift` is 0 in PLAY and saturates at `FADE_STEPS`.
- Banner:
  - Four glyphs L, O, S, E. Glyph k has its origin at `TEXT_X + k*(3*SEG_W+SEG_H)`, `TEXT_Y`.
  - Each glyph cell is `2*SEG_W+SEG_H` wide and `3*SEG_W+2*SEG_H` tall.
  - Seven segments per glyph:
    - top: full width, rows [0,`SEG_W`).
    - mid: full width, rows [`SEG_W+SEG_H`, `2*SEG_W+SEG_H`).
    - bottom: full width, last `SEG_W` rows.
    - UL/UR: `SEG_W`-wide column at the left or right edge, rows [0, `2*SEG_W+SEG_H`).
    - LL/LR: same columns, rows [`SEG_W+SEG_H`, cell height).
  - Segments lit per glyph:
    - L: UL, LL, bottom.
    - O: top, UL, UR, LL, LR, bottom.
    - S: top, UL, mid, LR, bottom.
    - E: top, UL, mid, LL, bottom.
- Output select: in MSG with `text_on`=1 and a banner hit, the output is `TEXT_COLOR`. In every other case it is the faded mix result.
- All coordinate arithmetic is done at 12 bits unsigned, with no wrap. Parameters are chosen so that the banner lies within 0..2047.

## Timing
- Reset state: `final_pixel`=0, `phase`=0, `shift`=0, all counters 0, `text_on`=0, pipeline registers 0.
- Latency: 2 cycles from `layers`/`hcount`/`vcount` to `final_pixel`.
  - Stage 1 registers the mix result and the banner hit.
  - Stage 2 registers the fade/select result.
- `shift`, `phase` and `text_on` change only on the cycle after `frame_start`, so no frame is drawn with mixed states. `phase` is registered and shows the new state one cycle after `frame_start`.
- Reset asserted mid-sequence returns the block to PLAY immediately and asynchronously. Operation resumes on the first `clk` edge after reset is released.

## Structure
- Package `compositor_pkg`: phase encoding, glyph segment masks (L/O/S/E as 7-bit constants), and the function computing glyph pitch.
- Sub-module `seg_glyph_hit`: combinational; inputs are relative x/y, the 7-bit segment mask and `SEG_W`/`SEG_H`; output is a hit flag. It is instantiated four times.
- The state machine, counters and pipeline live in the top module.

## Test plan
- OR mode: layers = {0x00F, 0x0F0, 0xF00, 0x000}, all enabled, `over`=0 → `final_pixel`=0xFFF two cycles later.
- Priority mode: layer0=0, layer1=0x123, layer2=0xF00 → output 0x123. Then set `layer_en[1]`=0 → output 0xF00.
- Assert `over`, then issue frames. Input pixel 0xFFF outputs as:
  - 0x777 on the first frame after FADE entry;
  - 0x333 after 8 frames;
  - 0x111 after 16 frames;
  - MSG entry after 24 frames.
- In MSG, pixel (TEXT_X, TEXT_Y+5) (L, UL segment) → 0x0FF for 30 frames, then 0x111 for 30 frames. A pixel inside the O's hollow interior → 0x111 throughout.
- Deassert `over` mid-FADE → the next frame returns `phase`=0 and unfaded output. Assert `rst`=0 mid-MSG → `final_pixel`=0 immediately.
- `frame_start` coincides with the `over` rising edge → `phase`=1 on the following cycle.

Source files
------------

// File: rtl/pixel_compositor_pkg.sv
// Shared constants for the pixel compositor: phase encoding, seven-segment
// bit positions, the LOSE glyph masks and the glyph pitch helper.
package compositor_pkg;

  localparam logic [1:0] PH_PLAY = 2'd0;
  localparam logic [1:0] PH_FADE = 2'd1;
  localparam logic [1:0] PH_MSG  = 2'd2;

  localparam int SEG_TOP = 0;
  localparam int SEG_MID = 1;
  localparam int SEG_BOT = 2;
  localparam int SEG_UL  = 3;
  localparam int SEG_UR  = 4;
  localparam int SEG_LL  = 5;
  localparam int SEG_LR  = 6;

  localparam logic [6:0] GLYPH_L = 7'b0101100;
  localparam logic [6:0] GLYPH_O = 7'b1111101;
  localparam logic [6:0] GLYPH_S = 7'b1001111;
  localparam logic [6:0] GLYPH_E = 7'b0101111;

  // Index k holds the k-th banner letter, left to right.
  localparam logic [3:0][6:0] BANNER_GLYPHS = {GLYPH_E, GLYPH_S, GLYPH_O, GLYPH_L};

  // Distance between glyph origins: cell width plus one segment of spacing.
  function automatic logic [11:0] glyph_pitch(input int seg_w, input int seg_h);
    return 12'(3 * seg_w + seg_h);
  endfunction

endpackage

// File: rtl/pixel_compositor_if.sv
// Pixel-side bus of the compositor: layer inputs, raster position, frame
// control and the composited output.
interface pixel_compositor_if #(
  parameter int NUM_LAYERS = 4,
  parameter int CH_W       = 4
);
  logic [NUM_LAYERS-1:0][3*CH_W-1:0] layers;
  logic [NUM_LAYERS-1:0]             layer_en;
  logic                              mix_mode;
  logic [10:0]                       hcount;
  logic [9:0]                        vcount;
  logic                              frame_start;
  logic                              over;
  logic [3*CH_W-1:0]                 final_pixel;
  logic [1:0]                        phase;

  modport master (
    output layers, layer_en, mix_mode, hcount, vcount, frame_start, over,
    input  final_pixel, phase
  );

  modport slave (
    input  layers, layer_en, mix_mode, hcount, vcount, frame_start, over,
    output final_pixel, phase
  );
endinterface

// File: rtl/seg_glyph_hit.sv
// Combinational seven-segment hit test for one glyph cell, given the pixel
// position relative to the cell origin and the lit-segment mask.
module seg_glyph_hit
  import compositor_pkg::*;
#(
  parameter int SEG_W = 10,
  parameter int SEG_H = 40
) (
  input  logic [11:0] rel_x,
  input  logic [11:0] rel_y,
  input  logic [6:0]  seg_mask,
  output logic        hit
);

  localparam logic [11:0] W      = 12'(SEG_W);
  localparam logic [11:0] CELL_W = 12'(2*SEG_W + SEG_H);
  localparam logic [11:0] CELL_H = 12'(3*SEG_W + 2*SEG_H);
  localparam logic [11:0] MID0   = 12'(SEG_W + SEG_H);
  localparam logic [11:0] MID1   = 12'(2*SEG_W + SEG_H);
  localparam logic [11:0] BOT0   = 12'(2*SEG_W + 2*SEG_H);

  logic       in_cell, left, right, top, mid, bot, upper, lower;
  logic [6:0] seg_on;

  always_comb begin
    in_cell = (rel_x < CELL_W) && (rel_y < CELL_H);
    left    = rel_x < W;
    right   = rel_x >= MID0;
    top     = rel_y < W;
    mid     = (rel_y >= MID0) && (rel_y < MID1);
    bot     = rel_y >= BOT0;
    upper   = rel_y < MID1;
    lower   = rel_y >= MID0;

    seg_on          = '0;
    seg_on[SEG_TOP] = top;
    seg_on[SEG_MID] = mid;
    seg_on[SEG_BOT] = bot;
    seg_on[SEG_UL]  = left  && upper;
    seg_on[SEG_UR]  = right && upper;
    seg_on[SEG_LL]  = left  && lower;
    seg_on[SEG_LR]  = right && lower;

    hit = in_cell && |(seg_on & seg_mask);
  end

endmodule

// File: rtl/pixel_compositor.sv
// Layer mixer, frame-synchronous game-over fade/banner sequencer and
// two-stage output pipeline in front of the VGA DAC.
module pixel_compositor
  import compositor_pkg::*;
#(
  parameter int                  NUM_LAYERS   = 4,
  parameter int                  CH_W         = 4,
  parameter int                  SEG_W        = 10,
  parameter int                  SEG_H        = 40,
  parameter int                  TEXT_X       = 120,
  parameter int                  TEXT_Y       = 245,
  parameter logic [3*CH_W-1:0]   TEXT_COLOR   = 'h0FF,
  parameter int                  FADE_STEPS   = 3,
  parameter int                  FADE_FRAMES  = 8,
  parameter int                  BLINK_FRAMES = 30
) (
  input logic               clk,
  input logic               rst,
  pixel_compositor_if.slave bus
);

  localparam int PIX_W = 3 * CH_W;
  localparam int SH_W  = $clog2(CH_W + 1);
  localparam int FC_W  = $clog2(FADE_FRAMES + 1);
  localparam int BC_W  = $clog2(BLINK_FRAMES + 1);

  logic [1:0]      state;
  logic [SH_W-1:0] shift;
  logic [FC_W-1:0] frame_cnt;
  logic [BC_W-1:0] blink_cnt;
  logic            text_on;

  // Sequencer only advances on frame_start so every drawn frame sees one state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= PH_PLAY;
      shift     <= '0;
      frame_cnt <= '0;
      blink_cnt <= '0;
      text_on   <= 1'b0;
    end else if (bus.frame_start) begin
      if (!bus.over) begin
        state     <= PH_PLAY;
        shift     <= '0;
        frame_cnt <= '0;
        blink_cnt <= '0;
        text_on   <= 1'b0;
      end else begin
        case (state)
          PH_PLAY: begin
            state     <= PH_FADE;
            shift     <= SH_W'(1);
            frame_cnt <= '0;
          end
          PH_FADE: begin
            if (frame_cnt == FC_W'(FADE_FRAMES - 1)) begin
              frame_cnt <= '0;
              if (shift == SH_W'(FADE_STEPS)) begin
                state     <= PH_MSG;
                blink_cnt <= '0;
                text_on   <= 1'b1;
              end else begin
                shift <= shift + SH_W'(1);
              end
            end else begin
              frame_cnt <= frame_cnt + FC_W'(1);
            end
          end
          PH_MSG: begin
            if (blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
              blink_cnt <= '0;
              text_on   <= ~text_on;
            end else begin
              blink_cnt <= blink_cnt + FC_W'(0) + BC_W'(1);
            end
          end
          default: state <= PH_PLAY;
        endcase
      end
    end
  end

  // Walking from the highest index down leaves the lowest nonzero layer in mix_pri.
  logic [PIX_W-1:0] mix_or, mix_pri, mix;
  always_comb begin
    mix_or  = '0;
    mix_pri = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (bus.layer_en[i]) begin
        mix_or = mix_or | bus.layers[i];
        if (bus.layers[i] != '0) mix_pri = bus.layers[i];
      end
    end
    mix = bus.mix_mode ? mix_pri : mix_or;
  end

  logic [11:0] hx, vy;
  logic [3:0]  glyph_hit;
  assign hx = {1'b0, bus.hcount};
  assign vy = {2'b0, bus.vcount};

  for (genvar k = 0; k < 4; k++) begin : g_glyph
    localparam logic [11:0] X0 = 12'(TEXT_X) + 12'(k) * glyph_pitch(SEG_W, SEG_H);
    localparam logic [11:0] Y0 = 12'(TEXT_Y);
    logic [11:0] rel_x, rel_y;
    // Left of / above the origin maps to all-ones, which is outside any cell.
    assign rel_x = (hx >= X0) ? hx - X0 : '1;
    assign rel_y = (vy >= Y0) ? vy - Y0 : '1;
    seg_glyph_hit #(.SEG_W(SEG_W), .SEG_H(SEG_H)) u_hit (
      .rel_x    (rel_x),
      .rel_y    (rel_y),
      .seg_mask (BANNER_GLYPHS[k]),
      .hit      (glyph_hit[k])
    );
  end

  logic [PIX_W-1:0] s1_mix;
  logic             s1_hit;
  logic [PIX_W-1:0] s2_pix;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_mix <= '0;
      s1_hit <= 1'b0;
    end else begin
      s1_mix <= mix;
      s1_hit <= |glyph_hit;
    end
  end

  logic [PIX_W-1:0] faded, sel;
  always_comb begin
    faded = '0;
    for (int c = 0; c < 3; c++) faded[c*CH_W +: CH_W] = s1_mix[c*CH_W +: CH_W] >> shift;
    sel = (state == PH_MSG && text_on && s1_hit) ? TEXT_COLOR : faded;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s2_pix <= '0;
    else      s2_pix <= sel;
  end

  assign bus.final_pixel = s2_pix;
  assign bus.phase       = state;

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed + randomized bench for pixel_compositor against a frame-count
// based reference model of the mix, fade and LOSE banner.
module tb_pixel_compositor;

  localparam int NL = 4;
  localparam int CW = 4;
  localparam int TX = 120;
  localparam int TY = 245;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pixel_compositor_if #(.NUM_LAYERS(NL), .CH_W(CW)) bus ();

  pixel_compositor #(.NUM_LAYERS(NL), .CH_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: whether the game-over sequence is running and how many
  // frame_start pulses have passed since it began.
  bit in_seq = 1'b0;
  int nfr    = 0;

  function automatic int phase_ref();
    if (!in_seq) return 0;
    return (nfr < 24) ? 1 : 2;
  endfunction

  function automatic int shift_ref();
    if (!in_seq) return 0;
    return (nfr < 24) ? 1 + nfr / 8 : 3;
  endfunction

  function automatic bit text_ref();
    return in_seq && nfr >= 24 && ((nfr - 24) / 30) % 2 == 0;
  endfunction

  function automatic bit banner_ref(input int h, input int v);
    bit lit = 0;
    for (int k = 0; k < 4; k++) begin
      int x0 = TX + 70 * k;
      if (h >= x0 && h < x0 + 60 && v >= TY && v < TY + 110) begin
        int rx = h - x0;
        int ry = v - TY;
        bit left  = rx < 10;
        bit right = rx >= 50;
        bit top   = ry < 10;
        bit mid   = ry >= 50 && ry < 60;
        bit bot   = ry >= 100;
        bit upper = ry < 60;
        bit lower = ry >= 50;
        case (k)
          0: lit = left || bot;
          1: lit = left || right || top || bot;
          2: lit = top || mid || bot || (left && upper) || (right && lower);
          default: lit = left || top || mid || bot;
        endcase
      end
    end
    return lit;
  endfunction

  function automatic logic [11:0] mix_ref(input logic [3:0][11:0] lay, input logic [3:0] en,
                                           input logic mode);
    logic [11:0] r = '0;
    if (!mode) begin
      for (int i = 0; i < NL; i++) if (en[i]) r = r | lay[i];
    end else begin
      for (int i = 0; i < NL; i++) if (en[i] && lay[i] != 0) begin r = lay[i]; break; end
    end
    return r;
  endfunction

  function automatic logic [11:0] exp_pix(input logic [3:0][11:0] lay, input logic [3:0] en,
                                           input logic mode, input int h, input int v);
    logic [11:0] m = mix_ref(lay, en, mode);
    logic [3:0]  r, g, b;
    int          sh = shift_ref();
    if (phase_ref() == 2 && text_ref() && banner_ref(h, v)) return 12'h0FF;
    r = m[11:8] >> sh;
    g = m[7:4]  >> sh;
    b = m[3:0]  >> sh;
    return {r, g, b};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one pixel, wait out the two-stage pipeline, sample after the edge.
  task automatic drive(input logic [3:0][11:0] lay, input logic [3:0] en, input logic mode,
                       input int h, input int v);
    bus.layers   = lay;
    bus.layer_en = en;
    bus.mix_mode = mode;
    bus.hcount   = 11'(h);
    bus.vcount   = 10'(v);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pix(input string tag, input logic [3:0][11:0] lay, input logic [3:0] en,
                     input logic mode, input int h, input int v);
    drive(lay, en, mode, h, v);
    check(tag, 32'(bus.final_pixel), 32'(exp_pix(lay, en, mode, h, v)));
  endtask

  task automatic rnd_pix(input string tag, input bit near_banner);
    logic [3:0][11:0] lay;
    int h, v;
    for (int i = 0; i < NL; i++) lay[i] = ($urandom_range(0, 2) == 0) ? 12'h0 : 12'($urandom);
    h = near_banner ? int'($urandom_range(110, 420)) : int'($urandom_range(0, 2047));
    v = near_banner ? int'($urandom_range(235, 365)) : int'($urandom_range(0, 1023));
    pix(tag, lay, 4'($urandom), 1'($urandom), h, v);
  endtask

  task automatic frame();
    bus.frame_start = 1'b1;
    @(posedge clk);
    #1;
    bus.frame_start = 1'b0;
    if (!bus.over) in_seq = 1'b0;
    else if (!in_seq) begin in_seq = 1'b1; nfr = 0; end
    else nfr++;
  endtask

  logic [3:0][11:0] white, orl, pri;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.layers      = '0;
    bus.layer_en    = '0;
    bus.mix_mode    = 1'b0;
    bus.hcount      = '0;
    bus.vcount      = '0;
    bus.frame_start = 1'b0;
    bus.over        = 1'b0;
    white = '0; white[0] = 12'hFFF;
    orl   = {12'h000, 12'hF00, 12'h0F0, 12'h00F};
    pri   = {12'h000, 12'hF00, 12'h123, 12'h000};

    #12;
    check("reset_pixel", 32'(bus.final_pixel), 32'h0);
    check("reset_phase", 32'(bus.phase), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    drive(orl, 4'hF, 1'b0, 0, 0);
    check("or_mode", 32'(bus.final_pixel), 32'hFFF);
    drive(pri, 4'hF, 1'b1, 0, 0);
    check("prio_l1", 32'(bus.final_pixel), 32'h123);
    drive(pri, 4'hD, 1'b1, 0, 0);
    check("prio_l2", 32'(bus.final_pixel), 32'hF00);
    for (int i = 0; i < 30; i++) rnd_pix("rand_play", i[0]);

    // over rising together with frame_start enters FADE on that pulse
    bus.over = 1'b1;
    frame();
    check("fade_entry_phase", 32'(bus.phase), 32'h1);
    drive(white, 4'hF, 1'b0, 5, 5);
    check("fade_shift1", 32'(bus.final_pixel), 32'h777);
    for (int f = 1; f <= 24; f++) begin
      frame();
      check("fade_phase", 32'(bus.phase), 32'(phase_ref()));
      rnd_pix("rand_fade", 1'b1);
      if (f == 8 || f == 16) begin
        drive(white, 4'hF, 1'b0, 5, 5);
        check("fade_step", 32'(bus.final_pixel), (f == 8) ? 32'h333 : 32'h111);
      end
    end
    check("msg_phase", 32'(bus.phase), 32'h2);

    // Blink: on for 30 frames, then off for 30, O interior never lit
    for (int f = 0; f < 64; f++) begin
      drive(white, 4'hF, 1'b0, TX, TY + 5);
      check("blink_ul", 32'(bus.final_pixel), (f < 30 || f >= 60) ? 32'h0FF : 32'h111);
      pix("blink_ul_model", white, 4'hF, 1'b0, TX, TY + 5);
      pix("o_hollow", white, 4'hF, 1'b0, TX + 70 + 30, TY + 30);
      if (f % 4 == 0) rnd_pix("rand_msg", 1'b1);
      frame();
    end

    // Drop over in MSG, then again mid-FADE
    bus.over = 1'b0;
    frame();
    check("msg_to_play", 32'(bus.phase), 32'h0);
    pix("play_unfaded", white, 4'hF, 1'b0, TX, TY + 5);
    bus.over = 1'b1;
    frame();
    repeat (5) frame();
    check("refade_phase", 32'(bus.phase), 32'h1);
    bus.over = 1'b0;
    @(posedge clk); #1;
    check("hold_until_frame", 32'(bus.phase), 32'h1);
    frame();
    check("fade_to_play", 32'(bus.phase), 32'h0);
    drive(white, 4'hF, 1'b0, 5, 5);
    check("fade_abort_pixel", 32'(bus.final_pixel), 32'hFFF);
    bus.over = 1'b1;
    frame();
    drive(white, 4'hF, 1'b0, 5, 5);
    check("refade_from_one", 32'(bus.final_pixel), 32'h777);

    // Reach MSG again and reset asynchronously with text lit
    repeat (24) frame();
    drive(white, 4'hF, 1'b0, TX, TY + 5);
    check("pre_reset_text", 32'(bus.final_pixel), 32'h0FF);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_pixel", 32'(bus.final_pixel), 32'h0);
    check("async_rst_phase", 32'(bus.phase), 32'h0);
    in_seq   = 1'b0;
    bus.over = 1'b0;
    #3;
    rst = 1'b1;
    @(posedge clk); #1;
    pix("post_reset", white, 4'hF, 1'b0, TX, TY + 5);
    for (int i = 0; i < 10; i++) rnd_pix("rand_post", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
